uart_rx_fsm: RTL and testbench
==============================

Name: uart_rx_fsm

Overview:
- Receive side of the UART link. Deserialises frames produced by the transmit path: start(0), 8 data bits LSB first, parity bit, stop(1).
- Idle line level is HIGH.
- Synchronises the asynchronous rx line, detects and validates the start bit, and samples each bit at its mid point.
- Presents the assembled byte with parity and framing status as a one-cycle valid strobe to the downstream consumer.

Parameters:
- CLKS_PER_BIT, 1, clk cycles per serial bit; 1 matches the transmitter's one-bit-per-clk rate; legal range 1..1024.
- SYNC_STAGES, 2, flops in the rx input synchroniser; legal range 2..4.
- PARITY_ODD, 0, 0 = even parity (parity bit = XOR of data), 1 = odd parity (inverted XOR).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rx  input  1  serial line, asynchronous to clk, idle HIGH
- data_out  output  8  received byte; updated only when data_valid rises, held otherwise
- data_valid  output  1  one-cycle strobe: frame complete, data_out/parity_err/frame_err valid
- parity_err  output  1  received parity bit mismatched computed parity; held until next data_valid
- frame_err  output  1  stop bit sampled LOW; held until next data_valid
- busy  output  1  high while a frame is in progress (START through STOP)

Behaviour:
- Reset values (immediate, asynchronous):
  - data_out=0x00, data_valid=0, parity_err=0, frame_err=0, busy=0.
  - All synchroniser flops=1.
  - Bit timer=0, bit counter=0.
  - State=WAIT_HIGH.
- rx_s: output of the last synchroniser stage. It lags rx by SYNC_STAGES cycles. The FSM sees only rx_s.
- Timing terms:
  - Bit timer tmr counts 0..CLKS_PER_BIT-1 within each bit period, then wraps to 0 and advances state or bit index.
  - MID=(CLKS_PER_BIT-1)/2, integer division.
  - "Sample" = rx_s value in the cycle where tmr==MID.
- WAIT_HIGH: go to IDLE on the first cycle with rx_s==1. This prevents a mid-frame reset release or a held-low line (break) from producing frames.
- IDLE:
  - On rx_s==0, that cycle is tmr=0 of the start bit.
  - If MID==0, the start bit is confirmed in this cycle: go to DATA if CLKS_PER_BIT==1, else go to START.
  - Otherwise go to START with tmr=1.
- START:
  - At tmr==MID, rx_s==1 is a false start: go to IDLE. No strobe, no flag change.
  - Otherwise continue to the end of the bit, then go to DATA with bit index 0.
- DATA:
  - At each sample, shift rx_s into the shift register, LSB first: bit index i lands in data bit i.
  - Fold rx_s into the running parity XOR.
  - After the bit-7 period ends, go to PARITY.
- PARITY:
  - At the sample, parity_bad = (rx_s != (XOR(data) ^ PARITY_ODD)).
  - At period end, go to STOP.
- STOP:
  - At the sample, in that same cycle, leave STOP without waiting for period end. This allows resynchronisation to a back-to-back frame.
  - rx_s==1: go to IDLE.
  - rx_s==0: go to WAIT_HIGH.
- Output update, registered, on the stop sample edge; all of the following are visible in the next cycle:
  - data_valid=1 for exactly one cycle.
  - data_out=shift register.
  - parity_err=parity_bad.
  - frame_err=!rx_s.
- A frame with errors still strobes data_valid.
- Latency with CLKS_PER_BIT=1 and SYNC_STAGES=2:
  - Start bit on rx at cycle 0; rx_s start sample at cycle 2; data samples at cycles 3..10; parity at 11; stop at 12.
  - data_valid high in cycle 13.
- busy: 1 in START, DATA, PARITY and STOP; 0 in IDLE and WAIT_HIGH. With CLKS_PER_BIT=1 it is high in cycles 3..12 of the example above.
- Back-to-back frames: the next start bit may immediately follow the stop bit on rx. No idle gap is required.
- Reset asserted mid-frame: the partial frame is discarded with no strobe, and the block enters WAIT_HIGH.

Test Plan:
- Basic frame, CLKS_PER_BIT=1, even parity: drive 0xA5 (line 0,1,0,1,0,0,1,0,1,0,1) -> data_valid in cycle 13 only; data_out=0xA5, parity_err=0, frame_err=0.
- Parity error: drive 0x3C with parity bit 1 (correct value is 0) -> data_valid, data_out=0x3C, parity_err=1, frame_err=0. A following correct frame of 0x01 with parity 1 clears it: parity_err=0.
- Framing error and break: drive 0xFF, parity 0, stop=0, then hold rx low 20 cycles, then high -> one data_valid with frame_err=1; no further strobes while low; next valid frame 0x55 is received cleanly.
- Back-to-back with a glitch, CLKS_PER_BIT=16:
  - Drive frames 0x00 then 0xFF with no gap -> two strobes 176 cycles apart; data_out 0x00 then 0xFF.
  - A 3-cycle low pulse while idle -> no strobe, busy returns to 0.
- Reset mid-frame: assert reset during data bit 4 of 0x81 -> all outputs 0 immediately; no strobe for the partial frame; the next full frame 0x7E is received correctly.
- Loopback with the transmitter at CLKS_PER_BIT=1: send 0x00, 0xFF, 0xA5, 0x5A -> four strobes with matching data, zero error flags.

Source files
------------

// File: rtl/uart_rx_fsm.sv
// UART receiver: synchronises rx, validates the start bit, samples every bit at mid-period and
// strobes out the byte together with parity and framing status.
module uart_rx_fsm #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned TW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned MID = (CLKS_PER_BIT - 1) / 2;
  localparam logic [TW-1:0] TMR_MID  = TW'(MID);
  localparam logic [TW-1:0] TMR_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StWaitHigh,
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e               state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 rx_s;
  logic [TW-1:0]        tmr_q;
  logic [2:0]           bit_idx_q;
  logic [7:0]           shift_q;
  logic                 par_q;
  logic                 par_bad_q;
  logic                 at_mid;
  logic                 at_last;

  // Synchroniser presets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign at_mid  = (tmr_q == TMR_MID);
  assign at_last = (tmr_q == TMR_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StWaitHigh;
      tmr_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      par_bad_q  <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state_q)
        StWaitHigh: begin
          tmr_q <= '0;
          if (rx_s) begin
            state_q <= StIdle;
          end
        end

        StIdle: begin
          if (!rx_s) begin
            busy      <= 1'b1;
            par_q     <= 1'b0;
            bit_idx_q <= '0;
            // The falling edge itself is tmr=0 of the start bit.
            if (CLKS_PER_BIT == 1) begin
              state_q <= StData;
              tmr_q   <= '0;
            end else begin
              state_q <= StStart;
              tmr_q   <= TW'(1);
            end
          end
        end

        StStart: begin
          if (at_mid && rx_s) begin
            state_q <= StIdle;
            tmr_q   <= '0;
            busy    <= 1'b0;
          end else if (at_last) begin
            state_q <= StData;
            tmr_q   <= '0;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end

        StData: begin
          if (at_mid) begin
            shift_q <= {rx_s, shift_q[7:1]};
            par_q   <= par_q ^ rx_s;
          end
          if (at_last) begin
            tmr_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= StParity;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end

        StParity: begin
          if (at_mid) begin
            par_bad_q <= (rx_s != (par_q ^ PARITY_ODD));
          end
          if (at_last) begin
            state_q <= StStop;
            tmr_q   <= '0;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end

        StStop: begin
          // Leave at the sample so a back-to-back start bit is caught on its first cycle.
          if (at_mid) begin
            data_valid <= 1'b1;
            data_out   <= shift_q;
            parity_err <= par_bad_q;
            frame_err  <= !rx_s;
            busy       <= 1'b0;
            tmr_q      <= '0;
            state_q    <= rx_s ? StIdle : StWaitHigh;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end

        default: begin
          state_q <= StWaitHigh;
          tmr_q   <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: three instances at different bit rates/parity, driven by a frame-level
// transmitter model; strobes are logged and compared against expected frames and arrival cycles.
module tb_uart_rx_fsm;

  typedef struct packed {
    logic [1:0]  inst;
    logic [31:0] cyc;
    logic [7:0]  data;
    logic        pe;
    logic        fe;
  } rec_t;

  logic       clk;
  logic       reset;
  logic       rxl  [3];
  logic [7:0] dout [3];
  logic       dv   [3];
  logic       pe   [3];
  logic       fe   [3];
  logic       bsy  [3];

  int   cyc;
  int   checks;
  int   failures;
  rec_t cap_q[$];
  rec_t exp_q[$];
  rec_t mon_r;

  uart_rx_fsm #(.CLKS_PER_BIT(1), .SYNC_STAGES(2), .PARITY_ODD(1'b0)) u_a (
    .clk(clk), .reset(reset), .rx(rxl[0]), .data_out(dout[0]), .data_valid(dv[0]),
    .parity_err(pe[0]), .frame_err(fe[0]), .busy(bsy[0])
  );
  uart_rx_fsm #(.CLKS_PER_BIT(16), .SYNC_STAGES(2), .PARITY_ODD(1'b0)) u_b (
    .clk(clk), .reset(reset), .rx(rxl[1]), .data_out(dout[1]), .data_valid(dv[1]),
    .parity_err(pe[1]), .frame_err(fe[1]), .busy(bsy[1])
  );
  uart_rx_fsm #(.CLKS_PER_BIT(5), .SYNC_STAGES(3), .PARITY_ODD(1'b1)) u_c (
    .clk(clk), .reset(reset), .rx(rxl[2]), .data_out(dout[2]), .data_valid(dv[2]),
    .parity_err(pe[2]), .frame_err(fe[2]), .busy(bsy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (dv[i] === 1'b1) begin
        mon_r.inst = 2'(i);
        mon_r.cyc  = cyc;
        mon_r.data = dout[i];
        mon_r.pe   = pe[i];
        mon_r.fe   = fe[i];
        cap_q.push_back(mon_r);
      end
    end
  end

  function automatic int cpb_of(input int inst);
    case (inst)
      0:       return 1;
      1:       return 16;
      default: return 5;
    endcase
  endfunction

  function automatic int ss_of(input int inst);
    return (inst == 2) ? 3 : 2;
  endfunction

  function automatic logic odd_of(input int inst);
    return (inst == 2) ? 1'b1 : 1'b0;
  endfunction

  // Transmitter model: start, 8 data LSB first, parity, stop; records the expected strobe.
  task automatic send_frame(input int inst, input logic [7:0] d, input logic pbit,
                            input logic stop);
    logic [10:0] bits;
    rec_t        r;
    int          cpb;
    cpb    = cpb_of(inst);
    bits   = {stop, pbit, d, 1'b0};
    r.inst = 2'(inst);
    r.cyc  = cyc + ss_of(inst) + 10 * cpb + (cpb - 1) / 2 + 1;
    r.data = d;
    r.pe   = (pbit != ((^d) ^ odd_of(inst)));
    r.fe   = !stop;
    exp_q.push_back(r);
    for (int b = 0; b < 11; b++) begin
      rxl[inst] = bits[b];
      repeat (cpb) @(negedge clk);
    end
  endtask

  task automatic idle_line(input int inst, input int n);
    rxl[inst] = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) rxl[i] = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({dout[i], dv[i], pe[i], fe[i], bsy[i]} !== 12'h000) begin
        failures++;
        $display("FAIL reset_values inst%0d: got %h, expected 000", i,
                 {dout[i], dv[i], pe[i], fe[i], bsy[i]});
      end
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (cap_q.size() != 0 || bsy[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_quiet: strobes=%0d busy=%b, expected 0 and 0", cap_q.size(), bsy[0]);
    end
    clear_logs();
  endtask

  task automatic test_basic();
    logic [10:0] bits;
    bits = 11'b1_0_10100101_0;
    for (int k = 0; k < 16; k++) begin
      rxl[0] = (k <= 10) ? bits[k] : 1'b1;
      checks++;
      if (bsy[0] !== ((k >= 3) && (k <= 12))) begin
        failures++;
        $display("FAIL basic_busy cycle %0d: got %b, expected %b", k, bsy[0],
                 (k >= 3) && (k <= 12));
      end
      checks++;
      if (dv[0] !== (k == 13)) begin
        failures++;
        $display("FAIL basic_valid cycle %0d: got %b, expected %b", k, dv[0], k == 13);
      end
      if (k == 13) begin
        checks++;
        if ({dout[0], pe[0], fe[0]} !== {8'hA5, 1'b0, 1'b0}) begin
          failures++;
          $display("FAIL basic_data: got data=%h pe=%b fe=%b, expected data=a5 pe=0 fe=0",
                   dout[0], pe[0], fe[0]);
        end
      end
      @(negedge clk);
    end
    clear_logs();
  endtask

  task automatic test_parity_err();
    clear_logs();
    send_frame(0, 8'h3C, 1'b1, 1'b1);
    send_frame(0, 8'h01, 1'b1, 1'b1);
    idle_line(0, 20);
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL parity_count: got %0d strobes, expected %0d", cap_q.size(), exp_q.size());
    end
    for (int k = 0; k < cap_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (cap_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL parity_frame%0d: got cyc=%0d data=%h pe=%b fe=%b, expected cyc=%0d data=%h pe=%b fe=%b",
                 k, cap_q[k].cyc, cap_q[k].data, cap_q[k].pe, cap_q[k].fe,
                 exp_q[k].cyc, exp_q[k].data, exp_q[k].pe, exp_q[k].fe);
      end
    end
  endtask

  task automatic test_frame_break();
    clear_logs();
    send_frame(0, 8'hFF, 1'b0, 1'b0);
    rxl[0] = 1'b0;
    repeat (20) @(negedge clk);
    idle_line(0, 10);
    send_frame(0, 8'h55, 1'b0, 1'b1);
    idle_line(0, 20);
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL break_count: got %0d strobes, expected %0d", cap_q.size(), exp_q.size());
    end
    for (int k = 0; k < cap_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (cap_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL break_frame%0d: got cyc=%0d data=%h pe=%b fe=%b, expected cyc=%0d data=%h pe=%b fe=%b",
                 k, cap_q[k].cyc, cap_q[k].data, cap_q[k].pe, cap_q[k].fe,
                 exp_q[k].cyc, exp_q[k].data, exp_q[k].pe, exp_q[k].fe);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    send_frame(1, 8'h00, 1'b0, 1'b1);
    send_frame(1, 8'hFF, 1'b0, 1'b1);
    idle_line(1, 60);
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL b2b_count: got %0d strobes, expected %0d", cap_q.size(), exp_q.size());
    end
    for (int k = 0; k < cap_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (cap_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL b2b_frame%0d: got cyc=%0d data=%h pe=%b fe=%b, expected cyc=%0d data=%h pe=%b fe=%b",
                 k, cap_q[k].cyc, cap_q[k].data, cap_q[k].pe, cap_q[k].fe,
                 exp_q[k].cyc, exp_q[k].data, exp_q[k].pe, exp_q[k].fe);
      end
    end
    if (cap_q.size() >= 2) begin
      checks++;
      if (cap_q[1].cyc - cap_q[0].cyc != 176) begin
        failures++;
        $display("FAIL b2b_spacing: got %0d cycles, expected 176", cap_q[1].cyc - cap_q[0].cyc);
      end
    end
    // Short low glitch: enters START, then rejected at the mid sample.
    rxl[1] = 1'b0;
    repeat (3) @(negedge clk);
    rxl[1] = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bsy[1] !== 1'b1) begin
      failures++;
      $display("FAIL glitch_busy_high: got %b, expected 1", bsy[1]);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (bsy[1] !== 1'b0 || cap_q.size() != 2) begin
      failures++;
      $display("FAIL glitch_reject: got busy=%b strobes=%0d, expected busy=0 strobes=2",
               bsy[1], cap_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] bits;
    clear_logs();
    bits = 11'b1_0_10000001_0;
    for (int b = 0; b < 5; b++) begin
      rxl[1] = bits[b];
      repeat (16) @(negedge clk);
    end
    rxl[1] = bits[5];
    repeat (8) @(negedge clk);
    checks++;
    if (bsy[1] !== 1'b1) begin
      failures++;
      $display("FAIL midreset_busy_before: got %b, expected 1", bsy[1]);
    end
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({dout[i], dv[i], pe[i], fe[i], bsy[i]} !== 12'h000) begin
        failures++;
        $display("FAIL midreset_async inst%0d: got %h, expected 000", i,
                 {dout[i], dv[i], pe[i], fe[i], bsy[i]});
      end
    end
    repeat (3) @(negedge clk);
    rxl[1] = 1'b1;
    reset = 1'b0;
    repeat (60) @(negedge clk);
    checks++;
    if (cap_q.size() != 0) begin
      failures++;
      $display("FAIL midreset_no_strobe: got %0d strobes, expected 0", cap_q.size());
    end
    send_frame(1, 8'h7E, 1'b0, 1'b1);
    idle_line(1, 40);
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL midreset_count: got %0d strobes, expected %0d", cap_q.size(), exp_q.size());
    end
    for (int k = 0; k < cap_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (cap_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL midreset_frame%0d: got cyc=%0d data=%h pe=%b fe=%b, expected cyc=%0d data=%h pe=%b fe=%b",
                 k, cap_q[k].cyc, cap_q[k].data, cap_q[k].pe, cap_q[k].fe,
                 exp_q[k].cyc, exp_q[k].data, exp_q[k].pe, exp_q[k].fe);
      end
    end
  endtask

  task automatic test_loopback();
    logic [7:0] d;
    logic [7:0] fixed [4];
    fixed[0] = 8'h00;
    fixed[1] = 8'hFF;
    fixed[2] = 8'hA5;
    fixed[3] = 8'h5A;
    clear_logs();
    for (int k = 0; k < 12; k++) begin
      d = (k < 4) ? fixed[k] : 8'($urandom_range(0, 255));
      send_frame(0, d, ^d, 1'b1);
    end
    idle_line(0, 20);
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL loop_count: got %0d strobes, expected %0d", cap_q.size(), exp_q.size());
    end
    for (int k = 0; k < cap_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (cap_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL loop_frame%0d: got cyc=%0d data=%h pe=%b fe=%b, expected cyc=%0d data=%h pe=%b fe=%b",
                 k, cap_q[k].cyc, cap_q[k].data, cap_q[k].pe, cap_q[k].fe,
                 exp_q[k].cyc, exp_q[k].data, exp_q[k].pe, exp_q[k].fe);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       bad_par;
    logic       stop;
    int         gap;
    clear_logs();
    for (int k = 0; k < 24; k++) begin
      d       = 8'($urandom_range(0, 255));
      bad_par = ($urandom_range(0, 3) == 0);
      stop    = ($urandom_range(0, 4) != 0);
      send_frame(2, d, (^d) ^ 1'b1 ^ bad_par, stop);
      // After a bad stop the receiver needs the line high before the next start.
      gap = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
      idle_line(2, gap * 5);
    end
    idle_line(2, 40);
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL random_count: got %0d strobes, expected %0d", cap_q.size(), exp_q.size());
    end
    for (int k = 0; k < cap_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (cap_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL random_frame%0d: got cyc=%0d data=%h pe=%b fe=%b, expected cyc=%0d data=%h pe=%b fe=%b",
                 k, cap_q[k].cyc, cap_q[k].data, cap_q[k].pe, cap_q[k].fe,
                 exp_q[k].cyc, exp_q[k].data, exp_q[k].pe, exp_q[k].fe);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    for (int i = 0; i < 3; i++) rxl[i] = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_parity_err();
    test_frame_break();
    test_back_to_back();
    test_reset_mid();
    test_loopback();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
